paralelo_serial: RTL and testbench
==================================

// Module: paralelo_serial
//
// PURPOSE
//  Per-lane parallel-to-serial converter in phy_tx, directly downstream of byte_striping.
//  - Instantiated once per lane; takes one 8-bit lane byte plus its valid flag.
//  - Shifts each byte out MSB first, one bit per clock.
//  - After reset, runs a sync phase of COM symbols; afterwards sends data, or IDLE when the lane byte is invalid.
//
// PARAMETERS
//  SYNC_COM  4      number of COM symbols sent after reset before data may go out (>=1)
//  COM_SYM   8'hBC  comma/sync symbol
//  IDLE_SYM  8'h7C  symbol sent in ACTIVE when valid_in=0
//
// PORTS
//  clk_8f    in   1  bit clock, 8x the lane byte rate; all logic on posedge
//  reset     in   1  asynchronous, active-low reset (0 = reset asserted)
//  data_in   in   8  lane byte from byte_striping (lane_0 or lane_1)
//  valid_in  in   1  lane byte valid
//  load      out  1  high for the one cycle whose closing posedge samples data_in/valid_in
//  active    out  1  high in state ACTIVE (sync phase done)
//  data_out  out  1  serial bit stream, MSB first
//
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=SYNC, com_cnt=0, bit_cnt=7, shreg=8'h00.
//   - Outputs: data_out=0, active=0, load=1 (load follows bit_cnt=7).
//  Counter: 3-bit bit_cnt increments every posedge, wraps 7->0.
//   - load = (bit_cnt==7), combinational from the register.
//  Load edge (posedge with bit_cnt==7):
//   - shreg <= selected byte; bit_cnt <= 0.
//   - Otherwise shreg <= {shreg[6:0],1'b0}.
//  data_out = shreg[7] (registered, no combinational path from data_in).
//   - Latency: data_in[7] appears on data_out 1 cycle after the load edge.
//   - Bit k appears k cycles later (k=0..7, counted from data_in[7]).
//  State machine (2 states, changes only on load edges):
//   - SYNC: selected byte = COM_SYM, data_in ignored, com_cnt++.
//     If com_cnt==SYNC_COM-1 on this load edge, go to ACTIVE (com_cnt saturates).
//     The first ACTIVE load is therefore the load after the last COM.
//   - ACTIVE: selected byte = valid_in ? data_in : IDLE_SYM. Stays in ACTIVE until reset.
//     active=1 from the edge that loads the last COM.
//  First load edge after reset release loads COM #1. Bytes are never stalled or dropped: every 8 cycles exactly one symbol is sent.
//  valid_in/data_in are don't-care except at load edges.
//  Reset mid-byte: the partial symbol is truncated (data_out goes 0 immediately) and the sync phase restarts from com_cnt=0.
//  No X on any output after reset, regardless of data_in/valid_in.
//
// TESTING
//  1. Hold reset=0 for 3 cycles -> data_out=0, active=0, load=1; no X.
//  2. Release reset -> bits 1,0,1,1,1,1,0,0 (8'hBC) x4 = 32 bits.
//     load pulses every 8 cycles; active=1 from the 4th COM load edge.
//  3. ACTIVE, valid_in=1 with data_in=FF, EE, DD, CC on consecutive loads -> 32 bits:
//     11111111 11101110 11011101 11001100.
//  4. ACTIVE, valid_in=0, data_in=$random -> 01111100 (IDLE_SYM), random data ignored.
//     Alternate valid 1/0 with 03/xx -> 00000011 then 01111100.
//  5. Assert reset 3 cycles into a data byte -> data_out=0 at once, active=0.
//     After release -> 4 x BC again before any data.
//  6. During SYNC drive valid_in=1, data_in=AA -> only BC is output; AA never appears.

Source files
------------

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial
//  Description : Per-lane parallel-to-serial converter, MSB first, with a
//                COM sync phase after reset and IDLE fill for invalid bytes.
//  Revision    : 1.0 - initial release
// ============================================================================

module paralelo_serial #(
    parameter int         SYNC_COM = 4,
    parameter logic [7:0] COM_SYM  = 8'hBC,
    parameter logic [7:0] IDLE_SYM = 8'h7C
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load,
    output logic       active,
    output logic       data_out
);

    localparam int                 c_CNT_W    = (SYNC_COM > 1) ? $clog2(SYNC_COM) : 1;
    localparam logic [c_CNT_W-1:0] c_COM_LAST = c_CNT_W'(SYNC_COM - 1);

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_com_cnt;
    logic [c_CNT_W-1:0] w_com_cnt_nxt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shreg;
    logic [7:0]         w_sym;

    assign load     = (r_bit_cnt == 3'd7);
    assign active   = (r_state == ST_ACTIVE);
    assign data_out = r_shreg[7];

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_SYNC;
            r_com_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_com_cnt <= w_com_cnt_nxt;
        end
    end

    // State and symbol selection only matter on load edges.
    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_sym         = COM_SYM;
        if (load) begin
            case (r_state)
                ST_SYNC: begin
                    w_sym = COM_SYM;
                    if (r_com_cnt == c_COM_LAST) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_com_cnt_nxt = r_com_cnt + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    w_sym = valid_in ? data_in : IDLE_SYM;
                end
                default: begin
                    w_state_nxt = ST_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= 3'd7;
            r_shreg   <= 8'h00;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (load) begin
                r_shreg <= w_sym;
            end else begin
                r_shreg <= {r_shreg[6:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paralelo_serial
//  Description : Scoreboard bench for paralelo_serial with a symbol-level model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_paralelo_serial;

    localparam int         SYNC_COM = 4;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    logic       clk_8f   = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       load;
    logic       active;
    logic       data_out;

    typedef struct packed {
        logic b;
        logic act;
        logic ld;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   sym_idx  = 0;
    bit   mon_en   = 1'b0;

    paralelo_serial #(
        .SYNC_COM (SYNC_COM),
        .COM_SYM  (COM_SYM),
        .IDLE_SYM (IDLE_SYM)
    ) dut (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .load     (load),
        .active   (active),
        .data_out (data_out)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t sym=%0d)", name, act, exp, $time, sym_idx);
        end
    endtask

    // Symbol n after reset: COM during the sync phase, then data or IDLE.
    function automatic logic [7:0] model_sym(input int n, input logic v, input logic [7:0] d);
        if (n < SYNC_COM) return COM_SYM;
        return v ? d : IDLE_SYM;
    endfunction

    // Called just before a load edge: drive the byte, queue its 8 bits.
    task automatic start_sym(input logic v, input logic [7:0] d);
        logic [7:0] s;
        exp_t       x;
        @(negedge clk_8f);
        valid_in = v;
        data_in  = d;
        s = model_sym(sym_idx, v, d);
        for (int i = 7; i >= 0; i--) begin
            x.b   = s[i];
            x.act = (sym_idx >= SYNC_COM - 1);
            x.ld  = (i == 0);
            exp_q.push_back(x);
        end
        @(posedge clk_8f);
        mon_en  = 1'b1;
        sym_idx = sym_idx + 1;
    endtask

    task automatic send_sym(input logic v, input logic [7:0] d);
        start_sym(v, d);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_8f);
            data_in  = 8'($urandom);
            valid_in = 1'($urandom);
            @(posedge clk_8f);
        end
    endtask

    always @(negedge clk_8f) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL underflow: got output bit %b expected none queued (t=%0t)", data_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("data_out", data_out, e.b);
                check("active", active, e.act);
                check("load", load, e.ld);
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       v;

        // Reset held: quiet outputs, load high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            data_in  = 8'($urandom);
            valid_in = 1'($urandom);
            check("rst_data_out", data_out, 1'b0);
            check("rst_active", active, 1'b0);
            check("rst_load", load, 1'b1);
        end
        @(posedge clk_8f);
        #2 reset = 1'b1;

        // Sync phase with data offered: must still emit COM only.
        for (int i = 0; i < SYNC_COM; i++) send_sym(1'b1, 8'hAA);

        send_sym(1'b1, 8'hFF);
        send_sym(1'b1, 8'hEE);
        send_sym(1'b1, 8'hDD);
        send_sym(1'b1, 8'hCC);
        d = 8'($urandom);
        send_sym(1'b0, d);
        send_sym(1'b1, 8'h03);
        d = 8'($urandom);
        send_sym(1'b0, d);

        for (int i = 0; i < 30; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            send_sym(v, d);
        end

        // Reset three cycles into a data byte.
        start_sym(1'b1, 8'h5A);
        repeat (2) @(posedge clk_8f);
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        reset  = 1'b0;
        #1;
        check("midrst_data_out", data_out, 1'b0);
        check("midrst_active", active, 1'b0);
        check("midrst_load", load, 1'b1);
        repeat (3) @(posedge clk_8f);
        #2 reset = 1'b1;
        sym_idx = 0;

        for (int i = 0; i < SYNC_COM; i++) send_sym(1'b1, 8'hAA);
        for (int i = 0; i < 10; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            send_sym(v, d);
        end

        for (int k = 0; k < 16 && exp_q.size() != 0; k++) begin
            @(negedge clk_8f);
            #1;
        end
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d bits pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
